// File: rtl/id_hazard_controller_if.sv
// Signal bundle between the ID/EX pipeline stages and the hazard controller.
// The master drives the decoded ID/EX view; the slave returns the pipeline controls.
interface id_hazard_controller_if;
  logic       i_id_valid;
  logic [5:0] i_id_opcode;
  logic [5:0] i_id_funct;
  logic [4:0] i_id_rs;
  logic [4:0] i_id_rt;
  logic       i_ex_valid;
  logic       i_ex_memread;
  logic [4:0] i_ex_rt;
  logic       i_branch_taken;

  logic        o_pc_write;
  logic        o_ifid_write;
  logic        o_ifid_flush;
  logic        o_idex_bubble;
  logic        o_md_busy;
  logic [4:0]  o_md_count;
  logic [15:0] o_stall_cycles;
  logic [15:0] o_flush_count;

  modport master (
    output i_id_valid, i_id_opcode, i_id_funct, i_id_rs, i_id_rt,
           i_ex_valid, i_ex_memread, i_ex_rt, i_branch_taken,
    input  o_pc_write, o_ifid_write, o_ifid_flush, o_idex_bubble,
           o_md_busy, o_md_count, o_stall_cycles, o_flush_count
  );

  modport slave (
    input  i_id_valid, i_id_opcode, i_id_funct, i_id_rs, i_id_rt,
           i_ex_valid, i_ex_memread, i_ex_rt, i_branch_taken,
    output o_pc_write, o_ifid_write, o_ifid_flush, o_idex_bubble,
           o_md_busy, o_md_count, o_stall_cycles, o_flush_count
  );
endinterface

// File: rtl/id_hazard_controller.sv
// ID-stage hazard controller: load-use and HI/LO (mult/div) stalls, branch/jump flushes.
// Define ID_HAZARD_STATS_EN to build the saturating stall/flush performance counters.
module id_hazard_controller #(
  parameter int unsigned MULT_LAT = 4,
  parameter int unsigned DIV_LAT  = 12
) (
  input logic                  i_clk,
  input logic                  i_reset,
  id_hazard_controller_if.slave bus
);

  typedef enum logic {RUN, MD_WAIT} state_e;

  state_e     state_q;
  logic [4:0] md_count_q;

  logic       id_is_rtype;
  logic       id_uses_rt;
  logic       id_is_md;
  logic       id_is_md_issue;
  logic       id_is_jump;
  logic       load_use;
  logic       md_hazard;
  logic       flush;
  logic       stall;
  logic       issue;
  logic [4:0] issue_lat;

  always_comb begin
    id_is_rtype    = (bus.i_id_opcode == 6'h00);
    id_uses_rt     = bus.i_id_opcode inside {6'h00, 6'h04, 6'h05, 6'h2B};
    id_is_md       = id_is_rtype && (bus.i_id_funct inside {[6'h10:6'h13], [6'h18:6'h1B]});
    id_is_md_issue = id_is_rtype && (bus.i_id_funct inside {[6'h18:6'h1B]});
    id_is_jump     = bus.i_id_opcode inside {6'h02, 6'h03};

    load_use  = bus.i_id_valid && bus.i_ex_valid && bus.i_ex_memread && (bus.i_ex_rt != 5'd0) &&
                ((bus.i_ex_rt == bus.i_id_rs) || ((bus.i_ex_rt == bus.i_id_rt) && id_uses_rt));
    md_hazard = bus.i_id_valid && id_is_md && (md_count_q != 5'd0);

    flush = bus.i_branch_taken;
    stall = !flush && (load_use || md_hazard);
    issue = bus.i_id_valid && id_is_md_issue && !flush && !stall;

    // div/divu (funct 0x1A/0x1B) are the only issuing functs with bit 1 set
    issue_lat = bus.i_id_funct[1] ? 5'(DIV_LAT) : 5'(MULT_LAT);
  end

  // NOTE: every output gets its run value first so no path through the
  // if-chain leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    bus.o_pc_write    = 1'b1;
    bus.o_ifid_write  = 1'b1;
    bus.o_ifid_flush  = 1'b0;
    bus.o_idex_bubble = 1'b0;
    if (i_reset) begin
      // run values while reset is held
    end else if (flush) begin
      bus.o_ifid_flush  = 1'b1;
      bus.o_idex_bubble = 1'b1;
    end else if (stall) begin
      bus.o_pc_write    = 1'b0;
      bus.o_ifid_write  = 1'b0;
      bus.o_idex_bubble = 1'b1;
    end else if (bus.i_id_valid && id_is_jump) begin
      bus.o_ifid_flush  = 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= RUN;
      md_count_q <= 5'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (issue) begin
            state_q    <= MD_WAIT;
            md_count_q <= issue_lat;
          end
        end
        MD_WAIT: begin
          if (issue) begin
            md_count_q <= issue_lat;
          end else if (md_count_q <= 5'd1) begin
            state_q    <= RUN;
            md_count_q <= 5'd0;
          end else begin
            md_count_q <= md_count_q - 5'd1;
          end
        end
        default: begin
          state_q    <= RUN;
          md_count_q <= 5'd0;
        end
      endcase
    end
  end

  assign bus.o_md_count = md_count_q;
  assign bus.o_md_busy  = (md_count_q != 5'd0);

`ifdef ID_HAZARD_STATS_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_count_q,  flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (stall && (stall_cycles_q != 16'hFFFF)) stall_cycles_d = stall_cycles_q + 16'd1;
    if (flush && (flush_count_q  != 16'hFFFF)) flush_count_d  = flush_count_q  + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stall_cycles_q <= 16'd0;
      flush_count_q  <= 16'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign bus.o_stall_cycles = stall_cycles_q;
  assign bus.o_flush_count  = flush_count_q;
`else
  assign bus.o_stall_cycles = 16'd0;
  assign bus.o_flush_count  = 16'd0;
`endif

endmodule

// File: tb/tb_id_hazard_controller.sv
// Directed scoreboard bench for id_hazard_controller (MULT_LAT=4, DIV_LAT=12).
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares.
module tb_id_hazard_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_hazard_controller_if bus_if ();

  id_hazard_controller #(.MULT_LAT(4), .DIV_LAT(12)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus_if)
  );

  typedef struct {
    string       name;
    logic [3:0]  ctrl;      // {pc_write, ifid_write, ifid_flush, idex_bubble}
    logic [4:0]  cnt;
    logic [15:0] stalls;
    logic [15:0] flushes;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;
  int tally_stall = 0;
  int tally_flush = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic drive(input logic r, input logic idv, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt, input logic exv,
                       input logic exm, input logic [4:0] ext, input logic br);
    @(posedge clk);
    #1;
    rst                   = r;
    bus_if.i_id_valid     = idv;
    bus_if.i_id_opcode    = op;
    bus_if.i_id_funct     = fn;
    bus_if.i_id_rs        = rs;
    bus_if.i_id_rt        = rt;
    bus_if.i_ex_valid     = exv;
    bus_if.i_ex_memread   = exm;
    bus_if.i_ex_rt        = ext;
    bus_if.i_branch_taken = br;
  endtask

  task automatic expect_c(input string name, input logic [3:0] ctrl, input logic [4:0] cnt);
    exp_t e;
    e.name = name;
    e.ctrl = ctrl;
    e.cnt  = cnt;
`ifdef ID_HAZARD_STATS_EN
    e.stalls  = (tally_stall > 65535) ? 16'hFFFF : 16'(tally_stall);
    e.flushes = (tally_flush > 65535) ? 16'hFFFF : 16'(tally_flush);
`else
    e.stalls  = 16'd0;
    e.flushes = 16'd0;
`endif
    exp_q.push_back(e);
    if (rst) begin
      tally_stall = 0;
      tally_flush = 0;
    end else if (ctrl == 4'b0001) begin
      tally_stall++;
    end else if (ctrl == 4'b1111) begin
      tally_flush++;
    end
  endtask

  localparam logic [3:0] RUNV  = 4'b1100;
  localparam logic [3:0] STALL = 4'b0001;
  localparam logic [3:0] FLUSH = 4'b1111;
  localparam logic [3:0] JUMP  = 4'b1110;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, ".ctrl"}, 16'({bus_if.o_pc_write, bus_if.o_ifid_write,
                                    bus_if.o_ifid_flush, bus_if.o_idex_bubble}), 16'(e.ctrl));
      check({e.name, ".md_count"}, 16'(bus_if.o_md_count), 16'(e.cnt));
      check({e.name, ".md_busy"}, 16'(bus_if.o_md_busy), 16'(e.cnt != 5'd0));
      check({e.name, ".stall_cycles"}, bus_if.o_stall_cycles, e.stalls);
      check({e.name, ".flush_count"}, bus_if.o_flush_count, e.flushes);
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst                   = 1'b1;
    bus_if.i_id_valid     = 1'b0;
    bus_if.i_id_opcode    = 6'h00;
    bus_if.i_id_funct     = 6'h00;
    bus_if.i_id_rs        = 5'd0;
    bus_if.i_id_rt        = 5'd0;
    bus_if.i_ex_valid     = 1'b0;
    bus_if.i_ex_memread   = 1'b0;
    bus_if.i_ex_rt        = 5'd0;
    bus_if.i_branch_taken = 1'b0;
    repeat (2) @(posedge clk);

    // reset held with a load-use hazard and a taken branch: run values
    drive(1, 1, 6'h00, 6'h20, 5'd5, 5'd6, 1, 1, 5'd5, 1); expect_c("reset_run", RUNV, 5'd0);
    drive(0, 0, 6'h00, 6'h00, 5'd0, 5'd0, 0, 0, 5'd0, 0); expect_c("idle", RUNV, 5'd0);

    // load-use via rs, then EX bubble releases
    drive(0, 1, 6'h00, 6'h20, 5'd5, 5'd6, 1, 1, 5'd5, 0); expect_c("lu_rs", STALL, 5'd0);
    drive(0, 1, 6'h00, 6'h20, 5'd5, 5'd6, 0, 0, 5'd0, 0); expect_c("lu_release", RUNV, 5'd0);
    // rt match counts only when ID uses rt (sw yes, lw no)
    drive(0, 1, 6'h2B, 6'h00, 5'd1, 5'd7, 1, 1, 5'd7, 0); expect_c("lu_rt_sw", STALL, 5'd0);
    drive(0, 1, 6'h23, 6'h00, 5'd1, 5'd7, 1, 1, 5'd7, 0); expect_c("lu_rt_lw", RUNV, 5'd0);
    drive(0, 1, 6'h00, 6'h20, 5'd0, 5'd0, 1, 1, 5'd0, 0); expect_c("zero_reg", RUNV, 5'd0);
    // jump flushes IF/ID, but a stall wins over it
    drive(0, 1, 6'h02, 6'h00, 5'd0, 5'd0, 0, 0, 5'd0, 0); expect_c("jump", JUMP, 5'd0);
    drive(0, 1, 6'h03, 6'h00, 5'd9, 5'd0, 1, 1, 5'd9, 0); expect_c("jump_stall", STALL, 5'd0);

    // mult issue, mflo waits out 4 cycles
    drive(1, 0, 6'h00, 6'h00, 5'd0, 5'd0, 0, 0, 5'd0, 0); expect_c("reset2", RUNV, 5'd0);
    drive(0, 1, 6'h00, 6'h18, 5'd1, 5'd2, 0, 0, 5'd0, 0); expect_c("mult_issue", RUNV, 5'd0);
    for (int i = 4; i >= 1; i--) begin
      drive(0, 1, 6'h00, 6'h12, 5'd0, 5'd0, 0, 0, 5'd0, 0); expect_c("mflo_wait", STALL, 5'(i));
    end
    drive(0, 1, 6'h00, 6'h12, 5'd0, 5'd0, 0, 0, 5'd0, 0); expect_c("mflo_go", RUNV, 5'd0);

    // divu issue, count continues through a flush, reset at count 7 abandons it
    drive(0, 1, 6'h00, 6'h1B, 5'd1, 5'd2, 0, 0, 5'd0, 0); expect_c("divu_issue", RUNV, 5'd0);
    drive(0, 1, 6'h00, 6'h10, 5'd0, 5'd0, 0, 0, 5'd0, 0); expect_c("mfhi_wait", STALL, 5'd12);
    drive(0, 1, 6'h00, 6'h10, 5'd0, 5'd0, 0, 0, 5'd0, 1); expect_c("md_flush", FLUSH, 5'd11);
    for (int i = 10; i >= 8; i--) begin
      drive(0, 1, 6'h00, 6'h10, 5'd0, 5'd0, 0, 0, 5'd0, 0); expect_c("mfhi_wait2", STALL, 5'(i));
    end
    drive(1, 1, 6'h00, 6'h10, 5'd0, 5'd0, 0, 0, 5'd0, 0); expect_c("reset_mid_div", RUNV, 5'd7);
    drive(0, 1, 6'h00, 6'h10, 5'd0, 5'd0, 0, 0, 5'd0, 0); expect_c("mfhi_after_rst", RUNV, 5'd0);

    // branch with load-use and div in ID: flush only, no issue
    drive(0, 1, 6'h00, 6'h1A, 5'd4, 5'd5, 1, 1, 5'd4, 1); expect_c("flush_all", FLUSH, 5'd0);
    drive(0, 0, 6'h00, 6'h00, 5'd0, 5'd0, 0, 0, 5'd0, 0); expect_c("no_load_flush", RUNV, 5'd0);
    // stalled multu does not load; mthi is not an issuing op
    drive(0, 1, 6'h00, 6'h19, 5'd3, 5'd0, 1, 1, 5'd3, 0); expect_c("mult_stalled", STALL, 5'd0);
    drive(0, 0, 6'h00, 6'h00, 5'd0, 5'd0, 0, 0, 5'd0, 0); expect_c("no_load_stall", RUNV, 5'd0);
    drive(0, 1, 6'h00, 6'h11, 5'd1, 5'd0, 0, 0, 5'd0, 0); expect_c("mthi", RUNV, 5'd0);
    drive(0, 0, 6'h00, 6'h00, 5'd0, 5'd0, 0, 0, 5'd0, 0); expect_c("mthi_noload", RUNV, 5'd0);

`ifdef ID_HAZARD_STATS_EN
    // stall counter saturates at 0xFFFF
    drive(1, 0, 6'h00, 6'h00, 5'd0, 5'd0, 0, 0, 5'd0, 0); expect_c("reset_sat", RUNV, 5'd0);
    for (int i = 0; i < 70000; i++) begin
      drive(0, 1, 6'h00, 6'h20, 5'd5, 5'd6, 1, 1, 5'd5, 0); expect_c("sat_stall", STALL, 5'd0);
    end
    drive(0, 0, 6'h00, 6'h00, 5'd0, 5'd0, 0, 0, 5'd0, 0); expect_c("sat_final", RUNV, 5'd0);
`endif

    drive(0, 0, 6'h00, 6'h00, 5'd0, 5'd0, 0, 0, 5'd0, 0);
    @(negedge clk);
    #1;
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
